mem_access_sequencer: RTL

Multi-cycle data-memory sequencer between the execute stage and the word-wide data memory. It accepts one load or store per handshake and applies the byte/half/word size and signedness that the instruction decoder produces (size 00/01/11, load_signed). Sub-word stores are done as read-modify-write. The pipeline stalls until the response returns.

---
 rtl/mem_seq_pkg.sv | 49 ++++
 rtl/mem_access_sequencer_lane.sv | 53 +++++
 rtl/mem_access_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
// Shared types and helpers for the data-memory access sequencer.
// Optional feature macro: MEM_SEQ_BYTE_STROBE_EN (byte-strobed sub-word stores).
package mem_seq_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  // Access size encoding, shared with the decoder's word_size field.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic              write;
    logic [1:0]        size;
    logic              sgn;
    logic [WORD_W-1:0] wdata;
  } req_t;

  function automatic logic is_sub_word(input logic [1:0] size);
    return (size == SIZE_BYTE) || (size == SIZE_HALF);
  endfunction

  // Encoding 2'b10 falls into the word case on purpose.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return lo[0];
      default:   return lo != 2'b00;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] replicate_wdata(input logic [1:0] size,
                                                        input logic [WORD_W-1:0] wd);
    case (size)
      SIZE_BYTE: return {4{wd[7:0]}};
      SIZE_HALF: return {2{wd[15:0]}};
      default:   return wd;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_sequencer_lane.sv
// Little-endian lane alignment: load extract/extend, store merge, byte strobes.
// Strobe output exists only when MEM_SEQ_BYTE_STROBE_EN is defined.
module mem_lane_align
  import mem_seq_pkg::*;
(
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              sgn,
  input  logic [WORD_W-1:0] word,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] merged
`ifdef MEM_SEQ_BYTE_STROBE_EN
  ,
  output logic [BE_W-1:0]   be
`endif
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = word[{addr_lo, 3'b000} +: 8];
  assign half_v = word[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    load_data = word;
    merged    = wdata;
    case (size)
      SIZE_BYTE: begin
        load_data = {{24{sgn & byte_v[7]}}, byte_v};
        merged    = word;
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SIZE_HALF: begin
        load_data = {{16{sgn & half_v[15]}}, half_v};
        merged    = word;
        merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

`ifdef MEM_SEQ_BYTE_STROBE_EN
  always_comb begin
    case (size)
      SIZE_BYTE: be = BE_W'(4'b0001 << addr_lo);
      SIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   be = 4'b1111;
    endcase
  end
`endif

endmodule

// File: rtl/mem_access_sequencer.sv
// Load/store sequencer between execute stage and word-wide data memory.
// MEM_SEQ_BYTE_STROBE_EN adds mem_be and replaces sub-word read-modify-write with strobed writes.
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic              stall,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef MEM_SEQ_BYTE_STROBE_EN
  output logic [BE_W-1:0]   mem_be,
`endif
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  req_t              req_q, req_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
`ifdef MEM_SEQ_BYTE_STROBE_EN
  logic [BE_W-1:0]   be_q, be_d, al_be;
`endif

  // Aligner looks at the live request while idle, at the captured one otherwise.
  logic              sel_req;
  logic [1:0]        al_lo, al_size;
  logic              al_sgn;
  logic [WORD_W-1:0] al_wdata, load_data, merged;

  assign sel_req  = (state_q == S_IDLE);
  assign al_lo    = sel_req ? req_addr[1:0] : addr_q[1:0];
  assign al_size  = sel_req ? req_size : req_q.size;
  assign al_sgn   = sel_req ? req_signed : req_q.sgn;
  assign al_wdata = sel_req ? WORD_W'(req_wdata) : req_q.wdata;

  mem_lane_align u_align (
    .addr_lo   (al_lo),
    .size      (al_size),
    .sgn       (al_sgn),
    .word      (WORD_W'(mem_rdata)),
    .wdata     (al_wdata),
    .load_data (load_data),
    .merged    (merged)
`ifdef MEM_SEQ_BYTE_STROBE_EN
    ,
    .be        (al_be)
`endif
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    req_d       = req_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef MEM_SEQ_BYTE_STROBE_EN
    be_d        = be_q;
`endif
    req_ready   = 1'b0;
    stall       = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    rsp_valid   = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) begin
          addr_d      = req_addr;
          req_d       = '{write: req_write, size: req_size, sgn: req_signed,
                          wdata: WORD_W'(req_wdata)};
          mem_wdata_d = WORD_W'(req_wdata);
`ifdef MEM_SEQ_BYTE_STROBE_EN
          be_d        = req_write ? al_be : '1;
`endif
          if (is_misaligned(req_size, req_addr[1:0])) begin
            state_d     = S_RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (!req_write) begin
            state_d = S_READ;
          end else if (is_sub_word(req_size)) begin
`ifdef MEM_SEQ_BYTE_STROBE_EN
            state_d     = S_WRITE;
            mem_wdata_d = replicate_wdata(req_size, WORD_W'(req_wdata));
`else
            state_d = S_READ;
`endif
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_READ: begin
        stall  = 1'b1;
        mem_en = 1'b1;
        if (mem_ready) begin
          if (req_q.write) begin
            state_d     = S_WRITE;
            mem_wdata_d = merged;
          end else begin
            state_d     = S_RESP;
            rsp_rdata_d = load_data;
            rsp_err_d   = 1'b0;
          end
        end
      end
      S_WRITE: begin
        stall  = 1'b1;
        mem_en = 1'b1;
        mem_we = 1'b1;
        if (mem_ready) begin
          state_d     = S_RESP;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      req_q       <= '0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef MEM_SEQ_BYTE_STROBE_EN
      be_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef MEM_SEQ_BYTE_STROBE_EN
      be_q        <= be_d;
`endif
    end
  end

  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = DATA_W'(mem_wdata_q);
  assign rsp_rdata = DATA_W'(rsp_rdata_q);
  assign rsp_err   = rsp_err_q;
`ifdef MEM_SEQ_BYTE_STROBE_EN
  assign mem_be    = be_q;
`endif

endmodule
